paddle_ctrl: RTL and testbench



---
 rtl/paddle_ctrl_pkg.sv | 32 +++
 rtl/paddle_step.sv | 60 ++++++
 rtl/paddle_ctrl.sv | 127 ++++++++++++
 tb/tb_paddle_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/paddle_ctrl_pkg.sv
// Shared VGA timing constants, FSM state encoding and paddle geometry helpers.
// Declarations only: no latency and no flow control of its own.
package paddle_ctrl_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int Y_W          = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD_L = 2'd1,
    UPD_R = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic l_up;
    logic l_dn;
    logic r_up;
    logic r_dn;
  } btn_t;

  // Lowest legal top line: the paddle bottom sits on the last visible line.
  function automatic int ymax_of(input int v_active, input int height);
    return v_active - height;
  endfunction

  function automatic int yc_of(input int v_active, input int height);
    return (v_active - height) / 2;
  endfunction

endpackage

// File: rtl/paddle_step.sv
// Shared add/clamp step for one paddle: next y and next ramp count.
// Purely combinational, zero latency; no flow control, the FSM decides when results commit.
module paddle_step
  import paddle_ctrl_pkg::*;
#(
  parameter int HEIGHT      = 128,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int STEP        = 4,
  parameter int FAST_STEP   = 8,
  parameter int RAMP_FRAMES = 16,
  parameter int CW          = $clog2(RAMP_FRAMES + 1)
) (
  input  logic [Y_W-1:0] y,
  input  logic           up,
  input  logic           dn,
  input  logic           center,
  input  logic           pause,
  input  logic [CW-1:0]  cnt,
  output logic [Y_W-1:0] y_nxt,
  output logic [CW-1:0]  cnt_nxt
);

  localparam logic [10:0]    YMAX_W = 11'(ymax_of(V_ACTIVE, HEIGHT));
  localparam logic [Y_W-1:0] YC_Y   = Y_W'(yc_of(V_ACTIVE, HEIGHT));
  localparam logic [10:0]    STEP_W = 11'(STEP);
  localparam logic [10:0]    FAST_W = 11'(FAST_STEP);
  localparam logic [CW-1:0]  RAMP_C = CW'(RAMP_FRAMES);

  logic        ramped;
  logic [10:0] y_w;
  logic [10:0] s;
  logic [10:0] sum;

  // Step size is chosen from the count before this frame's increment.
  assign ramped = (cnt == RAMP_C);
  assign y_w    = {1'b0, y};
  assign s      = ramped ? FAST_W : STEP_W;
  assign sum    = y_w + s;

  always_comb begin
    y_nxt   = y;
    cnt_nxt = cnt;
    if (center) begin
      y_nxt   = YC_Y;
      cnt_nxt = '0;
    end else if (!pause) begin
      if (up == dn) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = ramped ? cnt : cnt + 1'b1;
        if (up) begin
          y_nxt = (y_w < s) ? '0 : Y_W'(y_w - s);
        end else begin
          y_nxt = (sum > YMAX_W) ? YMAX_W[Y_W-1:0] : sum[Y_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// Per-frame paddle position controller: updates left then right once per vertical blanking.
// Latency: y_left at tick+2, y_right and upd_done at tick+3; no backpressure, never stalls.
module paddle_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int HEIGHT      = 128,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int STEP        = 4,
  parameter int FAST_STEP   = 8,
  parameter int RAMP_FRAMES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [9:0]     vcount,
  input  logic           btn_l_up,
  input  logic           btn_l_dn,
  input  logic           btn_r_up,
  input  logic           btn_r_dn,
  input  logic           center,
  input  logic           pause,
  output logic [Y_W-1:0] y_left,
  output logic [Y_W-1:0] y_right,
  output logic           upd_done
);

  localparam int             CW     = $clog2(RAMP_FRAMES + 1);
  localparam logic [Y_W-1:0] YC_Y   = Y_W'(yc_of(V_ACTIVE, HEIGHT));
  localparam logic [9:0]     VBLANK = 10'(V_ACTIVE);

  if (HEIGHT >= V_ACTIVE) begin : g_bad_height
    $error("paddle_ctrl: HEIGHT must be smaller than V_ACTIVE");
  end
  if (STEP > FAST_STEP) begin : g_bad_step
    $error("paddle_ctrl: STEP must not exceed FAST_STEP");
  end

  btn_t           btn_meta;
  btn_t           btn_sync;
  logic [9:0]     vcount_q;
  logic           tick;
  state_t         state;
  logic [CW-1:0]  cnt_l;
  logic [CW-1:0]  cnt_r;

  logic           sel_r;
  logic [Y_W-1:0] y_cur;
  logic [Y_W-1:0] y_nxt;
  logic           up_cur;
  logic           dn_cur;
  logic [CW-1:0]  cnt_cur;
  logic [CW-1:0]  cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      vcount_q <= '0;
    end else begin
      btn_meta <= {btn_l_up, btn_l_dn, btn_r_up, btn_r_dn};
      btn_sync <= btn_meta;
      vcount_q <= vcount;
    end
  end

  // Edge detect on the first blanking line so a stalled vcount fires only once.
  assign tick = (vcount == VBLANK) && (vcount_q != VBLANK);

  assign sel_r   = (state == UPD_R);
  assign y_cur   = sel_r ? y_right        : y_left;
  assign up_cur  = sel_r ? btn_sync.r_up  : btn_sync.l_up;
  assign dn_cur  = sel_r ? btn_sync.r_dn  : btn_sync.l_dn;
  assign cnt_cur = sel_r ? cnt_r          : cnt_l;

  paddle_step #(
    .HEIGHT      (HEIGHT),
    .V_ACTIVE    (V_ACTIVE),
    .STEP        (STEP),
    .FAST_STEP   (FAST_STEP),
    .RAMP_FRAMES (RAMP_FRAMES),
    .CW          (CW)
  ) u_step (
    .y       (y_cur),
    .up      (up_cur),
    .dn      (dn_cur),
    .center  (center),
    .pause   (pause),
    .cnt     (cnt_cur),
    .y_nxt   (y_nxt),
    .cnt_nxt (cnt_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      y_left   <= YC_Y;
      y_right  <= YC_Y;
      cnt_l    <= '0;
      cnt_r    <= '0;
      upd_done <= 1'b0;
    end else begin
      upd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= UPD_L;
        end
        UPD_L: begin
          y_left <= y_nxt;
          cnt_l  <= cnt_nxt;
          state  <= UPD_R;
        end
        UPD_R: begin
          y_right  <= y_nxt;
          cnt_r    <= cnt_nxt;
          upd_done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: drives vcount frame by frame and checks hand-computed positions.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] vcount;
  logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic       center, pause;
  logic [9:0] y_left, y_right;
  logic       upd_done;

  int n_chk = 0;
  int n_pass = 0;
  int exp_l = 176;
  int exp_r = 176;

  always #5 clk = ~clk;

  paddle_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vcount   (vcount),
    .btn_l_up (btn_l_up),
    .btn_l_dn (btn_l_dn),
    .btn_r_up (btn_r_up),
    .btn_r_dn (btn_r_dn),
    .center   (center),
    .pause    (pause),
    .y_left   (y_left),
    .y_right  (y_right),
    .upd_done (upd_done)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // One frame: tick in cycle T, y_left new at T+2, y_right new and upd_done at T+3.
  task automatic frame(input string tag, input int nl, input int nr, input int extra);
    repeat (2) @(negedge clk);
    vcount = 10'd480;
    check_eq({tag, ".T.done"}, int'(upd_done), 0);
    @(negedge clk);
    check_eq({tag, ".T1.yl"}, int'(y_left), exp_l);
    check_eq({tag, ".T1.done"}, int'(upd_done), 0);
    @(negedge clk);
    check_eq({tag, ".T2.yl"}, int'(y_left), nl);
    check_eq({tag, ".T2.yr"}, int'(y_right), exp_r);
    check_eq({tag, ".T2.done"}, int'(upd_done), 0);
    @(negedge clk);
    check_eq({tag, ".T3.yr"}, int'(y_right), nr);
    check_eq({tag, ".T3.done"}, int'(upd_done), 1);
    exp_l = nl;
    exp_r = nr;
    @(negedge clk);
    check_eq({tag, ".T4.done"}, int'(upd_done), 0);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      check_eq({tag, ".stuck.done"}, int'(upd_done), 0);
    end
    vcount = 10'd100;
    @(negedge clk);
    check_eq({tag, ".end.yl"}, int'(y_left), exp_l);
    check_eq({tag, ".end.yr"}, int'(y_right), exp_r);
  endtask

  initial begin
    int el;
    int er;
    rst_n = 1'b0;
    vcount = 10'd0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    center = 1'b0; pause = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst.yl", int'(y_left), 176);
    check_eq("rst.yr", int'(y_right), 176);
    check_eq("rst.done", int'(upd_done), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) frame("idle", 176, 176, 0);

    btn_l_up = 1'b1;
    for (int i = 1; i <= 5; i++) frame("l_up", 176 - 4 * i, 176, 0);
    btn_l_up = 1'b0;

    btn_r_dn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      er = (i <= 16) ? 176 + 4 * i : 240 + 8 * (i - 16);
      frame("r_dn_ramp", 156, er, 0);
    end
    btn_r_dn = 1'b0;
    frame("r_release", 156, 272, 0);
    btn_r_dn = 1'b1;
    frame("r_repress", 156, 276, 0);
    btn_r_dn = 1'b0;
    frame("r_release2", 156, 276, 0);

    // Both paddles ramp towards their clamps at the same time.
    btn_l_up = 1'b1;
    btn_r_dn = 1'b1;
    for (int i = 1; i <= 29; i++) begin
      el = (i <= 16) ? 156 - 4 * i : 92 - 8 * (i - 16);
      if (el < 0) el = 0;
      er = (i <= 16) ? 276 + 4 * i : 340 + 8 * (i - 16);
      if (er > 352) er = 352;
      frame("clamp", el, er, 0);
    end

    btn_l_dn = 1'b1;
    frame("l_both", 0, 352, 0);
    btn_l_up = 1'b0;
    frame("l_ramp_clr", 4, 352, 0);
    center = 1'b1;
    frame("center", 176, 176, 0);
    center = 1'b0;
    frame("after_ctr", 180, 180, 0);
    pause = 1'b1;
    frame("pause1", 180, 180, 0);
    frame("pause2", 180, 180, 0);
    pause = 1'b0;
    frame("unpause", 184, 184, 0);

    repeat (2) @(negedge clk);
    vcount = 10'd480;
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst.T2.yl", int'(y_left), 188);
    check_eq("midrst.T2.yr", int'(y_right), 184);
    rst_n = 1'b0;
    #1;
    check_eq("midrst.async.yl", int'(y_left), 176);
    check_eq("midrst.async.yr", int'(y_right), 176);
    check_eq("midrst.async.done", int'(upd_done), 0);
    vcount = 10'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_l = 176;
    exp_r = 176;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst.idle.done", int'(upd_done), 0);
      check_eq("post_rst.idle.yr", int'(y_right), 176);
    end
    frame("post_rst_stuck", 180, 180, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
